// File: rtl/operand_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_wb_stage_if
// Purpose  : Instruction-issue handshake and external register-load port of
//            the operand-fetch / write-back stage.
// Signals  : instr[15:0]  {op[15:11], rd[10:8], rs[7:5], im[4:2], rsvd[1:0]}
//            instr_valid  instruction present (master -> slave)
//            instr_ready  stage can accept (slave -> master)
//            ext_we       external register write request
//            ext_addr     external write address
//            ext_data     external write data
// Modports : master = issuer/loader, slave = operand_wb_stage
// Revision : 1.0 - initial release
// ============================================================================
interface operand_wb_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             ext_we;
  logic [AW-1:0]    ext_addr;
  logic [WIDTH-1:0] ext_data;

  modport master (
    output instr, instr_valid, ext_we, ext_addr, ext_data,
    input  instr_ready
  );

  modport slave (
    input  instr, instr_valid, ext_we, ext_addr, ext_data,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/operand_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_wb_stage
// Purpose  : Operand-fetch / write-back stage around the 8-bit ALU. Takes one
//            instruction at a time through IDLE -> READ -> EXEC -> WB, reads
//            R[rd]/R[rs] from an internal register file, drives the ALU, then
//            writes the result back and latches the architectural flags.
// Ports    : clock, reset_n       clock / asynchronous active-low reset
//            bus (slave)          instruction handshake + external load port
//            alu_in1/in2/im/op    registered ALU operands and opcode
//            alu_res, alu_cf/zf/sf/of  ALU result and flags
//            flags                {CF,ZF,SF,OF} architectural flags
//            show_val             value captured by the last SHOWR
//            done                 one-cycle retire pulse (IDLE after WB)
// Revision : 1.0 - initial release
// ============================================================================
module operand_wb_stage #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  operand_wb_stage_if.slave         bus,
  output logic      [WIDTH-1:0]     alu_in1,
  output logic      [WIDTH-1:0]     alu_in2,
  output logic      [2:0]           alu_im,
  output logic      [4:0]           alu_op,
  input  wire logic [WIDTH-1:0]     alu_res,
  input  wire logic                 alu_cf,
  input  wire logic                 alu_zf,
  input  wire logic                 alu_sf,
  input  wire logic                 alu_of,
  output logic      [3:0]           flags,
  output logic      [WIDTH-1:0]     show_val,
  output logic                      done
);

  localparam int         AW       = $clog2(NREGS);
  localparam logic [4:0] C_OP_MOV = 5'b00110;
  localparam logic [4:0] C_OP_NOT = 5'b01000;
  localparam logic [4:0] C_OP_SHR = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_rs;
  logic [2:0]       r_im;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic [2:0]       r_alu_im;
  logic [4:0]       r_alu_op;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_show_val;
  logic             r_done;

  logic w_ready;
  logic w_wb_en;
  logic w_flag_en;
  logic w_show_en;

  // Reserved instruction bits carry no meaning in this stage.
  logic w_unused_rsvd;
  assign w_unused_rsvd = ^bus.instr[1:0];

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_wb_en   = 1'b0;
    w_flag_en = 1'b0;
    w_show_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) begin
          w_next = S_READ;
        end
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB: begin
        w_next = S_IDLE;
        // Write-back covers the two defined opcode groups; NOP, SHOWR and
        // the undefined encodings retire without touching the register file.
        w_wb_en   = ((r_op >= 5'b00001) && (r_op <= C_OP_MOV)) ||
                    ((r_op >= C_OP_NOT) && (r_op <= 5'b01110));
        // MOV and NOT move data only, so they leave the flags alone.
        w_flag_en = ((r_op >= 5'b00001) && (r_op <= 5'b00101)) ||
                    ((r_op >= 5'b01001) && (r_op <= 5'b01110));
        w_show_en = (r_op == C_OP_SHR);
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: instruction latch, register file, ALU drive, retire
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_im       <= '0;
      r_alu_in1  <= '0;
      r_alu_in2  <= '0;
      r_alu_im   <= '0;
      r_alu_op   <= '0;
      r_flags    <= '0;
      r_show_val <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= (r_state == S_WB);
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_op <= bus.instr[15:11];
            r_rd <= bus.instr[8+AW-1:8];
            r_rs <= bus.instr[5+AW-1:5];
            r_im <= bus.instr[4:2];
          end
          // The load port is only live here, so it never collides with the
          // WB write; a same-cycle load is visible to the following READ.
          if (bus.ext_we) begin
            r_regs[bus.ext_addr] <= bus.ext_data;
          end
        end
        S_READ: begin
          r_alu_in1 <= r_regs[r_rd];
          r_alu_in2 <= r_regs[r_rs];
          r_alu_im  <= r_im;
          r_alu_op  <= r_op;
        end
        S_WB: begin
          if (w_wb_en) begin
            r_regs[r_rd] <= alu_res;
          end
          if (w_flag_en) begin
            r_flags <= {alu_cf, alu_zf, alu_sf, alu_of};
          end
          if (w_show_en) begin
            r_show_val <= alu_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = w_ready;
  assign alu_in1         = r_alu_in1;
  assign alu_in2         = r_alu_in2;
  assign alu_im          = r_alu_im;
  assign alu_op          = r_alu_op;
  assign flags           = r_flags;
  assign show_val        = r_show_val;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_operand_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_wb_stage
// Purpose  : Directed self-checking bench for operand_wb_stage. The ALU is
//            played by the bench: each instruction drives a hand-computed
//            result and flag set. Register contents are observed by issuing
//            a NOP and reading alu_in1/alu_in2 during EXEC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_wb_stage;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_MOV   = 5'b00110;
  localparam logic [4:0] OP_UNDEF = 5'b00111;
  localparam logic [4:0] OP_SHOWR = 5'b11111;

  logic       clock;
  logic       reset_n;
  logic [7:0] alu_in1, alu_in2, alu_res, show_val;
  logic [2:0] alu_im;
  logic [4:0] alu_op;
  logic       alu_cf, alu_zf, alu_sf, alu_of;
  logic [3:0] flags;
  logic       done;

  int tests_run;
  int tests_failed;

  operand_wb_stage_if #(.WIDTH(8), .AW(3)) ifc ();

  operand_wb_stage #(.NREGS(8), .WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (ifc.slave),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_im   (alu_im),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_cf   (alu_cf),
    .alu_zf   (alu_zf),
    .alu_sf   (alu_sf),
    .alu_of   (alu_of),
    .flags    (flags),
    .show_val (show_val),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
    ifc.ext_we   = 1'b1;
    ifc.ext_addr = a;
    ifc.ext_data = d;
    step();
    ifc.ext_we   = 1'b0;
  endtask

  // Issues one instruction from an IDLE cycle and returns at the retire
  // cycle (#1 after the 4th edge counting the accept edge).
  task automatic run_instr(
    input  logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
    input  logic [2:0] im, input logic [7:0] res, input logic [3:0] fl,
    input  logic xw, input logic [2:0] xa, input logic [7:0] xd,
    output logic [7:0] o1, output logic [7:0] o2, output logic [4:0] oop,
    output logic [2:0] oim, output logic early, output logic dn);
    ifc.instr       = {op, rd, rs, im, 2'b00};
    ifc.instr_valid = 1'b1;
    ifc.ext_we      = xw;
    ifc.ext_addr    = xa;
    ifc.ext_data    = xd;
    alu_res         = res;
    {alu_cf, alu_zf, alu_sf, alu_of} = fl;
    step();                      // accepted -> READ
    ifc.instr_valid = 1'b0;
    ifc.ext_we      = 1'b0;
    early = done;
    step();                      // EXEC
    o1 = alu_in1; o2 = alu_in2; oop = alu_op; oim = alu_im;
    early = early | done;
    step();                      // WB
    early = early | done;
    step();                      // retire cycle
    dn = done;
  endtask

  task automatic test_reset();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    ext_write(3'd1, 8'h05);
    #2 reset_n = 1'b0;           // asynchronous, mid-cycle
    #1;
    tests_run++;
    if (flags !== 4'h0 || done !== 1'b0 || alu_op !== 5'd0 || ifc.instr_ready !== 1'b1 ||
        show_val !== 8'h00 || alu_in1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: flags=%h done=%b op=%h ready=%b show=%h in1=%h, need 0,0,0,1,0,0",
               flags, done, alu_op, ifc.instr_ready, show_val, alu_in1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    run_instr(OP_NOP, 3'd1, 3'd0, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'h00 || o2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_regs: R1=%h R0=%h, need 00 00", o1, o2);
    end
    tests_run++;
    if (flags !== 4'h0) begin
      tests_failed++;
      $display("FAIL nop_flags_hold: flags=%h, need 0", flags);
    end
  endtask

  task automatic test_add();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    ext_write(3'd1, 8'h7F);
    ext_write(3'd2, 8'h01);
    run_instr(OP_ADD, 3'd1, 3'd2, 3'd5, 8'h80, 4'b0011, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'h7F || o2 !== 8'h01 || oop !== OP_ADD || oim !== 3'd5) begin
      tests_failed++;
      $display("FAIL add_operands: in1=%h in2=%h op=%h im=%h, need 7f 01 01 5", o1, o2, oop, oim);
    end
    tests_run++;
    if (e !== 1'b0 || d !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_done_timing: early=%b done=%b, need 0 1", e, d);
    end
    tests_run++;
    if (flags !== 4'b0011) begin
      tests_failed++;
      $display("FAIL add_flags: flags=%b, need 0011", flags);
    end
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_one_cycle: done=%b, need 0", done);
    end
    tests_run++;
    if (alu_in1 !== 8'h7F || alu_op !== OP_ADD) begin
      tests_failed++;
      $display("FAIL alu_hold_after_wb: in1=%h op=%h, need 7f 01", alu_in1, alu_op);
    end
    run_instr(OP_NOP, 3'd1, 3'd2, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'h80 || o2 !== 8'h01) begin
      tests_failed++;
      $display("FAIL add_writeback: R1=%h R2=%h, need 80 01", o1, o2);
    end
  endtask

  task automatic test_showr();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    step();
    ext_write(3'd3, 8'hF0);
    run_instr(OP_SHOWR, 3'd3, 3'd0, 3'd0, 8'hF0, 4'b1100, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (show_val !== 8'hF0 || flags !== 4'b0011 || d !== 1'b1 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL showr: show=%h flags=%b done=%b early=%b, need f0 0011 1 0",
               show_val, flags, d, e);
    end
    run_instr(OP_NOP, 3'd3, 3'd3, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'hF0) begin
      tests_failed++;
      $display("FAIL showr_reg_unchanged: R3=%h, need f0", o1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    run_instr(OP_MOV, 3'd4, 3'd3, 3'd0, 8'hF0, 4'b1010, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (d !== 1'b1 || ifc.instr_ready !== 1'b1 || flags !== 4'b0011) begin
      tests_failed++;
      $display("FAIL mov_retire: done=%b ready=%b flags=%b, need 1 1 0011", d, ifc.instr_ready, flags);
    end
    // Issued in the done cycle of the MOV.
    run_instr(OP_NOP, 3'd4, 3'd3, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'hF0 || d !== 1'b1 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: R4=%h done=%b early=%b, need f0 1 0", o1, d, e);
    end
    run_instr(OP_UNDEF, 3'd4, 3'd0, 3'd0, 8'h55, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (d !== 1'b1 || flags !== 4'b0011) begin
      tests_failed++;
      $display("FAIL undef_retire: done=%b flags=%b, need 1 0011", d, flags);
    end
    run_instr(OP_NOP, 3'd4, 3'd0, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'hF0) begin
      tests_failed++;
      $display("FAIL undef_no_write: R4=%h, need f0", o1);
    end
  endtask

  task automatic test_ext_port();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    step();
    ifc.instr       = {OP_NOP, 3'd0, 3'd0, 3'd0, 2'b00};
    ifc.instr_valid = 1'b1;
    step();                      // READ
    ifc.instr_valid = 1'b0;
    step();                      // EXEC
    ifc.ext_we   = 1'b1;
    ifc.ext_addr = 3'd5;
    ifc.ext_data = 8'hAA;
    step();                      // WB
    ifc.ext_we   = 1'b0;
    step();                      // retire
    run_instr(OP_NOP, 3'd5, 3'd5, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL ext_ignored_exec: R5=%h, need 00", o1);
    end
    run_instr(OP_AND, 3'd5, 3'd5, 3'd0, 8'hAA, 4'b0010, 1'b1, 3'd5, 8'hAA, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'hAA || o2 !== 8'hAA) begin
      tests_failed++;
      $display("FAIL ext_same_cycle: in1=%h in2=%h, need aa aa", o1, o2);
    end
    tests_run++;
    if (flags !== 4'b0010 || d !== 1'b1) begin
      tests_failed++;
      $display("FAIL and_flags: flags=%b done=%b, need 0010 1", flags, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o1, o2; logic [4:0] oop; logic [2:0] oim; logic e, d;
    logic seen;
    ext_write(3'd1, 8'h01);
    ifc.instr       = {OP_ADD, 3'd1, 3'd1, 3'd0, 2'b00};
    ifc.instr_valid = 1'b1;
    alu_res         = 8'h02;
    {alu_cf, alu_zf, alu_sf, alu_of} = 4'b0000;
    step();                      // READ
    ifc.instr_valid = 1'b0;
    step();                      // EXEC
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (flags !== 4'h0 || ifc.instr_ready !== 1'b1 || alu_op !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: flags=%b ready=%b op=%h, need 0000 1 00",
               flags, ifc.instr_ready, alu_op);
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | done;
    end
    tests_run++;
    if (seen !== 1'b0 || ifc.instr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: done_seen=%b ready=%b, need 0 1", seen, ifc.instr_ready);
    end
    run_instr(OP_NOP, 3'd1, 3'd5, 3'd0, 8'h00, 4'hF, 1'b0, 3'd0, 8'h00, o1, o2, oop, oim, e, d);
    tests_run++;
    if (o1 !== 8'h00 || o2 !== 8'h00 || flags !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_regs: R1=%h R5=%h flags=%b, need 00 00 0000", o1, o2, flags);
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset_n         = 1'b0;
    ifc.instr       = 16'h0000;
    ifc.instr_valid = 1'b0;
    ifc.ext_we      = 1'b0;
    ifc.ext_addr    = 3'd0;
    ifc.ext_data    = 8'h00;
    alu_res         = 8'h00;
    {alu_cf, alu_zf, alu_sf, alu_of} = 4'b0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    test_reset();
    test_add();
    test_showr();
    test_back_to_back();
    test_ext_port();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
